i2c_slave_responder: RTL and testbench

- I2C target (slave) that sits at the far end of the bus from the team's I2C master.
- Samples the open-drain SCL/SDA lines on the system clock and detects START, repeated START and STOP.
- Matches a 7-bit address and ACKs it. Receives write bytes and hands them to the fabric; for reads, fetches bytes from the fabric and shifts them out.
- Bytes continue until STOP, so the master's multi-byte bursts are supported.

---
 rtl/i2c_pkg.sv | 19 +
 rtl/i2c_line_sync.sv | 46 ++++
 rtl/i2c_slave_responder.sv | 205 ++++++++++++++++++++
 tb/tb_i2c_slave_responder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target responder.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_RX_BYTE  = 3'd3,
        ST_RX_ACK   = 3'd4,
        ST_TX_LOAD  = 3'd5,
        ST_TX_BYTE  = 3'd6,
        ST_TX_ACK   = 3'd7
    } i2c_state_t;

    localparam int   BYTE_BITS = 8;
    localparam logic ACK       = 1'b0;
    localparam logic NACK      = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes the raw SCL/SDA levels and derives SCL edges plus
// START/STOP conditions. Idle bus level is high, so the chains reset to 1.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_q;
    logic                   sda_q;
    logic                   scl;

    // Synchronizer chains plus one history flop per line for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_q    <= scl_sync[SYNC_STAGES-1];
            sda_q    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl      = scl_sync[SYNC_STAGES-1];
    assign sda      = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl & ~scl_q;
    assign scl_fall = ~scl & scl_q;
    // SCL must be high in both samples so an SCL edge never looks like START/STOP.
    assign start    = scl & scl_q & sda_q & ~sda;
    assign stop     = scl & scl_q & ~sda_q & sda;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target: address match, write-byte receive, read-byte transmit.
// Optional clock stretching while waiting for read data: I2C_STRETCH_EN.
//
// state       | meaning
// ST_IDLE     | bus ignored until START
// ST_ADDR     | shifting address byte; cnt==8 means matched, ACK pending
// ST_ADDR_ACK | driving address ACK for one SCL low/high period
// ST_RX_BYTE  | shifting a write byte; cnt==8 means byte done, ACK pending
// ST_RX_ACK   | driving write-byte ACK
// ST_TX_LOAD  | fetching the next read byte from the fabric
// ST_TX_BYTE  | shifting a read byte out, MSB first
// ST_TX_ACK   | sampling master ACK/NACK; cnt==1 means ACK seen
module i2c_slave_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h01,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       scl_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       busy,
    output logic       rw
);

    localparam logic [3:0] CNT_LAST = 4'(BYTE_BITS - 1);
    localparam logic [3:0] CNT_DONE = 4'(BYTE_BITS);

    i2c_state_t              state;
    logic [3:0]              cnt;
    logic [BYTE_BITS-2:0]    shreg;
    logic                    sda_s;
    logic                    scl_rise;
    logic                    scl_fall;
    logic                    start_det;
    logic                    stop_det;

    i2c_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_line_sync (
        .clk      (clk),
        .rst_n    (reset),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda      (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start_det),
        .stop     (stop_det)
    );

`ifdef I2C_STRETCH_EN
    logic scl_oe_r;
    assign scl_oe = scl_oe_r;
`else
    logic unused_tx_valid;
    assign unused_tx_valid = tx_valid;
    assign scl_oe          = 1'b0;
`endif

    // Protocol FSM; bus conditions override bit handling in every state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            shreg    <= '0;
            sda_oe   <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            busy     <= 1'b0;
            rw       <= 1'b0;
`ifdef I2C_STRETCH_EN
            scl_oe_r <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
            if (stop_det) begin
                state  <= ST_IDLE;
                cnt    <= '0;
                sda_oe <= 1'b0;
                tx_req <= 1'b0;
                busy   <= 1'b0;
`ifdef I2C_STRETCH_EN
                scl_oe_r <= 1'b0;
`endif
            end else if (start_det) begin
                state  <= ST_ADDR;
                cnt    <= '0;
                sda_oe <= 1'b0;
                tx_req <= 1'b0;
`ifdef I2C_STRETCH_EN
                scl_oe_r <= 1'b0;
`endif
            end else begin
                case (state)
                    ST_IDLE: ;
                    ST_ADDR: begin
                        if (scl_rise && cnt < CNT_DONE) begin
                            shreg <= {shreg[BYTE_BITS-3:0], sda_s};
                            cnt   <= cnt + 4'd1;
                            if (cnt == CNT_LAST) begin
                                if (shreg == SLAVE_ADDR) begin
                                    rw   <= sda_s;
                                    busy <= 1'b1;
                                end else begin
                                    state <= ST_IDLE;
                                    cnt   <= '0;
                                    busy  <= 1'b0;
                                end
                            end
                        end else if (scl_fall && cnt == CNT_DONE) begin
                            sda_oe <= 1'b1;
                            state  <= ST_ADDR_ACK;
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            cnt    <= '0;
                            state  <= rw ? ST_TX_LOAD : ST_RX_BYTE;
                        end
                    end
                    ST_RX_BYTE: begin
                        if (scl_rise && cnt < CNT_DONE) begin
                            shreg <= {shreg[BYTE_BITS-3:0], sda_s};
                            cnt   <= cnt + 4'd1;
                            if (cnt == CNT_LAST) begin
                                rx_data  <= {shreg, sda_s};
                                rx_valid <= 1'b1;
                            end
                        end else if (scl_fall && cnt == CNT_DONE) begin
                            sda_oe <= 1'b1;
                            state  <= ST_RX_ACK;
                        end
                    end
                    ST_RX_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            cnt    <= '0;
                            state  <= ST_RX_BYTE;
                        end
                    end
                    ST_TX_LOAD: begin
`ifdef I2C_STRETCH_EN
                        if (tx_req && tx_valid) begin
`else
                        if (tx_req) begin
`endif
                            shreg  <= tx_data[BYTE_BITS-2:0];
                            sda_oe <= ~tx_data[BYTE_BITS-1];
                            tx_req <= 1'b0;
                            cnt    <= '0;
                            state  <= ST_TX_BYTE;
                        end else begin
                            tx_req <= 1'b1;
`ifdef I2C_STRETCH_EN
                            scl_oe_r <= 1'b1;
`endif
                        end
                    end
                    ST_TX_BYTE: begin
`ifdef I2C_STRETCH_EN
                        scl_oe_r <= 1'b0;
`endif
                        if (scl_fall) begin
                            if (cnt == CNT_LAST) begin
                                sda_oe <= 1'b0;
                                cnt    <= '0;
                                state  <= ST_TX_ACK;
                            end else begin
                                sda_oe <= ~shreg[BYTE_BITS-2];
                                shreg  <= {shreg[BYTE_BITS-3:0], 1'b0};
                                cnt    <= cnt + 4'd1;
                            end
                        end
                    end
                    ST_TX_ACK: begin
                        if (scl_rise) begin
                            if (sda_s == NACK) begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end else begin
                                cnt <= 4'd1;
                            end
                        end else if (scl_fall && cnt == 4'd1) begin
                            cnt   <= '0;
                            state <= ST_TX_LOAD;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Self-checking bench: bit-banged bus master, byte-level fabric, and a
// transaction-level expectation model (address match -> ACKs, write bytes
// delivered in order, read bytes taken from the fabric stream in order).
module tb_i2c_slave_responder;

    localparam int         Q      = 8;       // quarter SCL period in clk
    localparam logic [6:0] SLAVE  = 7'h01;
    localparam int         STRDLY = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       sda_oe, scl_oe, rx_valid, tx_req, busy, rw;
    logic [7:0] rx_data;

    wire scl_line = scl_m & ~scl_oe;
    wire sda_line = sda_m & ~sda_oe;

    i2c_slave_responder #(
        .SLAVE_ADDR  (SLAVE),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_line),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .scl_oe   (scl_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_req   (tx_req),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .busy     (busy),
        .rw       (rw)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Fabric and monitors
    logic [7:0] fab [0:255];
    int         fab_idx = 0;
    int         n_req = 0;
    int         n_stretch = 0;
    int         rxv_long = 0;
    int         wait_cnt = 0;
    logic       req_prev = 1'b0;
    logic       rxv_prev = 1'b0;
    logic [7:0] rx_q[$];

    always @(negedge clk) begin
        if (rx_valid) rx_q.push_back(rx_data);
        if (rx_valid && rxv_prev) rxv_long++;
        rxv_prev = rx_valid;
        if (tx_req && !req_prev) n_req++;
        if (req_prev && !tx_req) fab_idx++;
        req_prev = tx_req;
        if (scl_oe) n_stretch++;
        if (tx_req) begin
            wait_cnt++;
            tx_valid = (wait_cnt >= STRDLY);
        end else begin
            wait_cnt = 0;
            tx_valid = 1'b0;
        end
        tx_data = fab[fab_idx[7:0]];
    end

    // Expectation model state
    logic [7:0] exp_rx[$];
    int         exp_idx = 0;
    int         exp_req = 0;
    logic [7:0] wbuf [0:3];

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic m_start();
        sda_m = 1'b1; wclk(Q);
        scl_m = 1'b1; wclk(Q);
        sda_m = 1'b0; wclk(Q);
        scl_m = 1'b0; wclk(Q);
    endtask

    task automatic m_stop();
        sda_m = 1'b0; wclk(Q);
        scl_m = 1'b1; wclk(Q);
        sda_m = 1'b1; wclk(2 * Q);
    endtask

    task automatic m_bit(input logic b, output logic r);
        int k;
        sda_m = b; wclk(Q);
        scl_m = 1'b1;
        k = 0;
        while (scl_line !== 1'b1 && k < 400) begin
            wclk(1);
            k++;
        end
        if (k >= 400) chk("scl_stretch_timeout", 32'(scl_line), 32'd1);
        wclk(Q);
        r = sda_line;
        wclk(Q);
        scl_m = 1'b0; wclk(Q);
    endtask

    task automatic m_write(input logic [7:0] d, output logic ack);
        logic dummy;
        for (int i = 7; i >= 0; i--) m_bit(d[i], dummy);
        m_bit(1'b1, ack);
    endtask

    task automatic m_read(output logic [7:0] d, input logic mack);
        logic dummy;
        for (int i = 7; i >= 0; i--) m_bit(1'b1, d[i]);
        m_bit(mack, dummy);
    endtask

    task automatic check_streams(input string tag);
        chk({tag, "_rx_count"}, 32'(rx_q.size()), 32'(exp_rx.size()));
        while (rx_q.size() > 0 && exp_rx.size() > 0)
            chk({tag, "_rx_byte"}, 32'(rx_q.pop_front()), 32'(exp_rx.pop_front()));
        rx_q.delete();
        exp_rx.delete();
        chk({tag, "_tx_req_count"}, 32'(n_req), 32'(exp_req));
    endtask

    // One complete transaction: START, address, n bytes, STOP.
    task automatic run_txn(input string tag, input logic [6:0] addr, input logic rd, input int n);
        logic       ack;
        logic [7:0] d;
        logic       match;
        match = (addr == SLAVE);
        m_start();
        m_write({addr, rd}, ack);
        chk({tag, "_addr_ack"}, 32'(ack), match ? 32'd0 : 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'(match));
        if (match) begin
            chk({tag, "_rw"}, 32'(rw), 32'(rd));
            for (int i = 0; i < n; i++) begin
                if (!rd) begin
                    m_write(wbuf[i], ack);
                    chk({tag, "_data_ack"}, 32'(ack), 32'd0);
                    exp_rx.push_back(wbuf[i]);
                end else begin
                    m_read(d, (i == n - 1));
                    chk({tag, "_read_byte"}, 32'(d), 32'(fab[exp_idx[7:0]]));
                    exp_idx++;
                    exp_req++;
                end
            end
            if (rd) chk({tag, "_busy_after_nack"}, 32'(busy), 32'd0);
        end
        m_stop();
        chk({tag, "_busy_after_stop"}, 32'(busy), 32'd0);
        check_streams(tag);
    endtask

    initial begin
        logic       ack;
        logic       dummy;
        logic [7:0] d;
        for (int i = 0; i < 256; i++) fab[i] = 8'($urandom);
        fab[0] = 8'h07;
        fab[1] = 8'h0F;

        wclk(4);
        chk("rst_sda_oe", 32'(sda_oe), 0);
        chk("rst_scl_oe", 32'(scl_oe), 0);
        chk("rst_rx_data", 32'(rx_data), 0);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_tx_req", 32'(tx_req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rw", 32'(rw), 0);
        reset = 1'b1;
        wclk(4 * Q);

        // Directed write and read bursts
        wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
        run_txn("wr_burst", 7'h01, 1'b0, 2);
        run_txn("rd_burst", 7'h01, 1'b1, 2);
        run_txn("addr_miss", 7'h08, 1'b0, 0);

        // Repeated START from write into read
        m_start();
        m_write(8'h02, ack);  chk("rs_addr_ack", 32'(ack), 0);
        m_write(8'h5A, ack);  chk("rs_data_ack", 32'(ack), 0);
        exp_rx.push_back(8'h5A);
        m_start();
        m_write(8'h03, ack);  chk("rs_addr2_ack", 32'(ack), 0);
        chk("rs_rw", 32'(rw), 1);
        m_read(d, 1'b1);
        chk("rs_read_byte", 32'(d), 32'(fab[exp_idx[7:0]]));
        exp_idx++; exp_req++;
        m_stop();
        check_streams("rs");

        // STOP after four data bits: no delivery, back to idle
        m_start();
        m_write(8'h02, ack);  chk("ps_addr_ack", 32'(ack), 0);
        for (int i = 0; i < 4; i++) m_bit(1'($urandom), dummy);
        m_stop();
        chk("ps_busy", 32'(busy), 0);
        chk("ps_sda_oe", 32'(sda_oe), 0);
        check_streams("ps");

        // Async reset while the slave is driving the address ACK
        m_start();
        for (int i = 7; i >= 0; i--) m_bit(((8'h02 >> i) & 8'h01) != 0, dummy);
        sda_m = 1'b1;
        wclk(Q);
        chk("mr_sda_oe_pre", 32'(sda_oe), 1);
        chk("mr_busy_pre", 32'(busy), 1);
        reset = 1'b0;
        #1;
        chk("mr_sda_oe", 32'(sda_oe), 0);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_rx_data", 32'(rx_data), 0);
        chk("mr_tx_req", 32'(tx_req), 0);
        chk("mr_rw", 32'(rw), 0);
        chk("mr_scl_oe", 32'(scl_oe), 0);
        wclk(2);
        reset = 1'b1;
        scl_m = 1'b1;
        wclk(4 * Q);

`ifdef I2C_STRETCH_EN
        fab[exp_idx[7:0]] = 8'h81;
        n_stretch = 0;
        run_txn("stretch", SLAVE, 1'b1, 1);
        chk("stretch_len_ok", 32'(n_stretch >= STRDLY && n_stretch <= STRDLY + 2), 1);
`endif

        // Randomized transactions
        for (int t = 0; t < 10; t++) begin
            logic [6:0] a;
            logic       rd;
            int         n;
            a  = ($urandom_range(0, 2) != 0) ? SLAVE : 7'($urandom_range(0, 127));
            rd = 1'($urandom);
            n  = $urandom_range(1, 4);
            for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
            run_txn("rand", a, rd, n);
        end

        chk("rx_valid_one_cycle", 32'(rxv_long), 0);
`ifndef I2C_STRETCH_EN
        chk("scl_oe_tied_low", 32'(n_stretch), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
